// File: rtl/conv_window_addr_gen_if.sv
// ----------------------------------------------------------------------------
// conv_window_addr_gen_if
//   Bundles the command and address-stream signals of conv_window_addr_gen.
//
//   Command side (into the generator):
//     i_start, i_src1_start_addr, i_kernal_start_addr, i_dest_start_addr,
//     i_stride
//   Stream side:
//     i_ready      consumer accepts the current address pair
//     o_valid      o_src_addr / o_kern_addr / o_dest_addr / o_last_tap valid
//     o_src_addr, o_kern_addr, o_dest_addr, o_last_tap
//   Status:
//     o_busy, o_done
//
//   master : the address generator (drives o_*, reads i_*)
//   slave  : the controller / datapath (drives i_*, reads o_*)
// ----------------------------------------------------------------------------
interface conv_window_addr_gen_if #(
    parameter int ADDR_W = 10
);
    logic              i_start;
    logic [ADDR_W-1:0] i_src1_start_addr;
    logic [ADDR_W-1:0] i_kernal_start_addr;
    logic [ADDR_W-1:0] i_dest_start_addr;
    logic [2:0]        i_stride;
    logic              i_ready;
    logic              o_valid;
    logic [ADDR_W-1:0] o_src_addr;
    logic [ADDR_W-1:0] o_kern_addr;
    logic              o_last_tap;
    logic [ADDR_W-1:0] o_dest_addr;
    logic              o_busy;
    logic              o_done;

    modport master (
        input  i_start, i_src1_start_addr, i_kernal_start_addr,
               i_dest_start_addr, i_stride, i_ready,
        output o_valid, o_src_addr, o_kern_addr, o_last_tap,
               o_dest_addr, o_busy, o_done
    );

    modport slave (
        output i_start, i_src1_start_addr, i_kernal_start_addr,
               i_dest_start_addr, i_stride, i_ready,
        input  o_valid, o_src_addr, o_kern_addr, o_last_tap,
               o_dest_addr, o_busy, o_done
    );
endinterface

// File: rtl/conv_window_addr_gen.sv
// ----------------------------------------------------------------------------
// conv_window_addr_gen
//   Sliding-window address generator feeding the convolution datapath.
//   After a start command it walks every fully-fitting K_DIM x K_DIM window
//   of an IMG_DIM x IMG_DIM source tile at the programmed stride and streams
//   one (source, kernel, destination) address set per handshake.
//
//   Ports:
//     i_clk   rising-edge clock
//     i_rst   asynchronous active-low reset
//     bus     conv_window_addr_gen_if.master (command, address stream, status)
//
//   Tap order: kx fastest, then ky. Window order: ox fastest, then oy.
//   All address sums wrap modulo 2^ADDR_W.
// ----------------------------------------------------------------------------
module conv_window_addr_gen #(
    parameter int IMG_DIM = 8,
    parameter int K_DIM   = 3,
    parameter int ADDR_W  = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    conv_window_addr_gen_if.master bus
);

    // Largest legal window origin on either axis.
    localparam int LIM = IMG_DIM - K_DIM;
    // Origin width leaves room for origin + max stride (7) without overflow,
    // so the fit test below is a plain unsigned compare.
    localparam int CW  = $clog2(IMG_DIM + 8) + 1;
    localparam int KW  = (K_DIM > 1) ? $clog2(K_DIM) : 1;
    localparam int WW  = $clog2(IMG_DIM * IMG_DIM + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [KW-1:0] K_LAST = KW'(K_DIM - 1);

    // ---------------------------------------------------------------- state
    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] src_base_q,  src_base_d;
    logic [ADDR_W-1:0] kern_base_q, kern_base_d;
    logic [ADDR_W-1:0] dest_base_q, dest_base_d;
    logic [2:0]        stride_q,    stride_d;
    logic [CW-1:0]     oy_q,        oy_d;
    logic [CW-1:0]     ox_q,        ox_d;
    logic [KW-1:0]     ky_q,        ky_d;
    logic [KW-1:0]     kx_q,        kx_d;
    logic [WW-1:0]     win_q,       win_d;

    logic              valid_q,     valid_d;
    logic [ADDR_W-1:0] src_q,       src_d;
    logic [ADDR_W-1:0] kern_q,      kern_d;
    logic              last_q,      last_d;
    logic [ADDR_W-1:0] dest_q,      dest_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    // ---------------------------------------------------- address functions
    function automatic logic [ADDR_W-1:0] src_addr(
        input logic [ADDR_W-1:0] base,
        input logic [CW-1:0]     oy,
        input logic [KW-1:0]     ky,
        input logic [CW-1:0]     ox,
        input logic [KW-1:0]     kx
    );
        return ADDR_W'(32'(base) + (32'(oy) + 32'(ky)) * 32'(IMG_DIM)
                       + 32'(ox) + 32'(kx));
    endfunction

    function automatic logic [ADDR_W-1:0] kern_addr(
        input logic [ADDR_W-1:0] base,
        input logic [KW-1:0]     ky,
        input logic [KW-1:0]     kx
    );
        return ADDR_W'(32'(base) + 32'(ky) * 32'(K_DIM) + 32'(kx));
    endfunction

    function automatic logic [ADDR_W-1:0] dest_addr(
        input logic [ADDR_W-1:0] base,
        input logic [WW-1:0]     win
    );
        return ADDR_W'(32'(base) + 32'(win));
    endfunction

    // ------------------------------------------------------- walk position
    logic          kx_end, ky_end, col_end, row_end, final_tap, hs;
    logic [CW-1:0] ox_step, oy_step;
    logic [CW-1:0] adv_ox, adv_oy;
    logic [KW-1:0] adv_kx, adv_ky;
    logic [WW-1:0] adv_win;

    assign kx_end    = (kx_q == K_LAST);
    assign ky_end    = (ky_q == K_LAST);
    assign ox_step   = ox_q + CW'(stride_q);
    assign oy_step   = oy_q + CW'(stride_q);
    // A window that would overhang the tile edge is never generated.
    assign col_end   = (ox_step > CW'(LIM));
    assign row_end   = (oy_step > CW'(LIM));
    assign final_tap = kx_end & ky_end & col_end & row_end;
    assign hs        = valid_q & bus.i_ready;

    // Position of the tap that follows the current one.
    always_comb begin
        adv_kx  = kx_q;
        adv_ky  = ky_q;
        adv_ox  = ox_q;
        adv_oy  = oy_q;
        adv_win = win_q;
        if (!kx_end) begin
            adv_kx = kx_q + KW'(1);
        end else begin
            adv_kx = '0;
            if (!ky_end) begin
                adv_ky = ky_q + KW'(1);
            end else begin
                adv_ky  = '0;
                adv_win = win_q + WW'(1);
                if (!col_end) begin
                    adv_ox = ox_step;
                end else begin
                    adv_ox = '0;
                    adv_oy = oy_step;
                end
            end
        end
    end

    // -------------------------------------------------------- next state
    always_comb begin
        state_d     = state_q;
        src_base_d  = src_base_q;
        kern_base_d = kern_base_q;
        dest_base_d = dest_base_q;
        stride_d    = stride_q;
        oy_d        = oy_q;
        ox_d        = ox_q;
        ky_d        = ky_q;
        kx_d        = kx_q;
        win_d       = win_q;
        valid_d     = valid_q;
        src_d       = src_q;
        kern_d      = kern_q;
        last_d      = last_q;
        dest_d      = dest_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d     = ST_RUN;
                    src_base_d  = bus.i_src1_start_addr;
                    kern_base_d = bus.i_kernal_start_addr;
                    dest_base_d = bus.i_dest_start_addr;
                    stride_d    = (bus.i_stride == 3'd0) ? 3'd1 : bus.i_stride;
                    oy_d        = '0;
                    ox_d        = '0;
                    ky_d        = '0;
                    kx_d        = '0;
                    win_d       = '0;
                end
            end
            ST_RUN: begin
                if (!valid_q) begin
                    // First RUN cycle: present the pair for the cleared origin.
                    valid_d = 1'b1;
                    src_d   = src_addr(src_base_q, oy_q, ky_q, ox_q, kx_q);
                    kern_d  = kern_addr(kern_base_q, ky_q, kx_q);
                    dest_d  = dest_addr(dest_base_q, win_q);
                    last_d  = kx_end & ky_end;
                end else if (hs) begin
                    if (final_tap) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        oy_d   = adv_oy;
                        ox_d   = adv_ox;
                        ky_d   = adv_ky;
                        kx_d   = adv_kx;
                        win_d  = adv_win;
                        src_d  = src_addr(src_base_q, adv_oy, adv_ky, adv_ox, adv_kx);
                        kern_d = kern_addr(kern_base_q, adv_ky, adv_kx);
                        dest_d = dest_addr(dest_base_q, adv_win);
                        last_d = (adv_kx == K_LAST) && (adv_ky == K_LAST);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            src_base_q  <= '0;
            kern_base_q <= '0;
            dest_base_q <= '0;
            stride_q    <= '0;
            oy_q        <= '0;
            ox_q        <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            win_q       <= '0;
            valid_q     <= 1'b0;
            src_q       <= '0;
            kern_q      <= '0;
            last_q      <= 1'b0;
            dest_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_base_q  <= src_base_d;
            kern_base_q <= kern_base_d;
            dest_base_q <= dest_base_d;
            stride_q    <= stride_d;
            oy_q        <= oy_d;
            ox_q        <= ox_d;
            ky_q        <= ky_d;
            kx_q        <= kx_d;
            win_q       <= win_d;
            valid_q     <= valid_d;
            src_q       <= src_d;
            kern_q      <= kern_d;
            last_q      <= last_d;
            dest_q      <= dest_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_src_addr  = src_q;
    assign bus.o_kern_addr = kern_q;
    assign bus.o_last_tap  = last_q;
    assign bus.o_dest_addr = dest_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
module tb_conv_window_addr_gen;

    localparam int IMG = 8;
    localparam int K   = 3;
    localparam int AW  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_window_addr_gen_if #(.ADDR_W(AW)) bus ();

    conv_window_addr_gen #(.IMG_DIM(IMG), .K_DIM(K), .ADDR_W(AW)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Captured handshakes of the latest run.
    int cap_src  [512];
    int cap_kern [512];
    int cap_dest [512];
    int cap_last [512];
    int cap_n;
    int cap_cycles;
    int cap_busy1;
    int cap_valid1;

    // Reference sequence built from the address formulas.
    int exp_src  [512];
    int exp_kern [512];
    int exp_dest [512];
    int exp_last [512];
    int exp_n;
    int mm_idx;

    task automatic build_model(input int stride, input int sb, input int kb, input int db);
        int s;
        int w;
        s = (stride == 0) ? 1 : stride;
        w = 0;
        exp_n = 0;
        for (int oy = 0; oy <= IMG - K; oy += s) begin
            for (int ox = 0; ox <= IMG - K; ox += s) begin
                for (int ky = 0; ky < K; ky++) begin
                    for (int kx = 0; kx < K; kx++) begin
                        exp_src[exp_n]  = (sb + (oy + ky) * IMG + ox + kx) % 1024;
                        exp_kern[exp_n] = (kb + ky * K + kx) % 1024;
                        exp_dest[exp_n] = (db + w) % 1024;
                        exp_last[exp_n] = (ky == K - 1 && kx == K - 1) ? 1 : 0;
                        exp_n++;
                    end
                end
                w++;
            end
        end
    endtask

    // Number of differing captured entries (plus any length difference).
    function automatic int model_mismatch();
        int bad;
        int n;
        bad = 0;
        mm_idx = -1;
        n = (cap_n < exp_n) ? cap_n : exp_n;
        for (int i = 0; i < n; i++) begin
            if (cap_src[i] != exp_src[i] || cap_kern[i] != exp_kern[i] ||
                cap_dest[i] != exp_dest[i] || cap_last[i] != exp_last[i]) begin
                if (mm_idx < 0) mm_idx = i;
                bad++;
            end
        end
        bad += (cap_n > exp_n) ? cap_n - exp_n : exp_n - cap_n;
        return bad;
    endfunction

    // Start a run and capture every handshake until o_done (bounded).
    task automatic run(input int stride, input int sb, input int kb, input int db,
                       input bit rand_ready, input int poke_at);
        int       cyc;
        bit       done_seen;
        bit       prev_stall;
        logic [AW-1:0] ps, pk, pd;
        logic     pl;
        logic     rdy;
        cyc = 0;
        done_seen = 1'b0;
        prev_stall = 1'b0;
        ps = '0; pk = '0; pd = '0; pl = 1'b0;
        cap_n = 0;
        @(negedge clk);
        bus.i_stride            = 3'(stride);
        bus.i_src1_start_addr   = AW'(sb);
        bus.i_kernal_start_addr = AW'(kb);
        bus.i_dest_start_addr   = AW'(db);
        bus.i_start             = 1'b1;
        bus.i_ready             = 1'b1;
        while (!done_seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                cap_busy1  = int'(bus.o_busy);
                cap_valid1 = int'(bus.o_valid);
            end
            bus.i_start = (cyc == poke_at);
            if (cyc == poke_at) begin
                bus.i_stride            = 3'd5;
                bus.i_src1_start_addr   = 10'd777;
                bus.i_kernal_start_addr = 10'd333;
                bus.i_dest_start_addr   = 10'd555;
            end
            if (prev_stall) begin
                tests++;
                if ({bus.o_valid, bus.o_src_addr, bus.o_kern_addr, bus.o_dest_addr, bus.o_last_tap}
                    !== {1'b1, ps, pk, pd, pl}) begin
                    fails++;
                    $display("FAIL stall_hold cyc %0d: src %0d kern %0d dest %0d last %0b valid %0b, required src %0d kern %0d dest %0d last %0b valid 1",
                             cyc, bus.o_src_addr, bus.o_kern_addr, bus.o_dest_addr,
                             bus.o_last_tap, bus.o_valid, ps, pk, pd, pl);
                end
            end
            if (bus.o_done) begin
                done_seen = 1'b1;
            end else begin
                rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
                bus.i_ready = rdy;
                if (bus.o_valid && rdy && cap_n < 512) begin
                    cap_src[cap_n]  = int'(bus.o_src_addr);
                    cap_kern[cap_n] = int'(bus.o_kern_addr);
                    cap_dest[cap_n] = int'(bus.o_dest_addr);
                    cap_last[cap_n] = int'(bus.o_last_tap);
                    cap_n++;
                end
                prev_stall = bus.o_valid && !rdy;
                ps = bus.o_src_addr;
                pk = bus.o_kern_addr;
                pd = bus.o_dest_addr;
                pl = bus.o_last_tap;
            end
        end
        cap_cycles = cyc;
        if (!done_seen) begin
            tests++;
            fails++;
            bus.i_start = 1'b0;
            $display("FAIL run_timeout: no o_done after %0d cycles, required o_done", cyc);
        end else begin
            tests++;
            if ({bus.o_valid, bus.o_busy} !== 2'b00) begin
                fails++;
                $display("FAIL done_flags: valid %0b busy %0b, required 0 0", bus.o_valid, bus.o_busy);
            end
            @(negedge clk);
            bus.i_start = 1'b0;
            tests++;
            if (bus.o_done !== 1'b0) begin
                fails++;
                $display("FAIL done_width: o_done %0b one cycle later, required 0", bus.o_done);
            end
        end
        bus.i_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (bus.o_valid !== 1'b0)     begin fails++; $display("FAIL rst_valid: %0b, required 0", bus.o_valid); end
        tests++; if (bus.o_src_addr !== '0)    begin fails++; $display("FAIL rst_src: %0d, required 0", bus.o_src_addr); end
        tests++; if (bus.o_kern_addr !== '0)   begin fails++; $display("FAIL rst_kern: %0d, required 0", bus.o_kern_addr); end
        tests++; if (bus.o_last_tap !== 1'b0)  begin fails++; $display("FAIL rst_last: %0b, required 0", bus.o_last_tap); end
        tests++; if (bus.o_dest_addr !== '0)   begin fails++; $display("FAIL rst_dest: %0d, required 0", bus.o_dest_addr); end
        tests++; if (bus.o_busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: %0b, required 0", bus.o_busy); end
        tests++; if (bus.o_done !== 1'b0)      begin fails++; $display("FAIL rst_done: %0b, required 0", bus.o_done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.o_valid, bus.o_busy, bus.o_done} !== 3'b000) begin
            fails++;
            $display("FAIL idle_after_reset: valid %0b busy %0b done %0b, required 0 0 0",
                     bus.o_valid, bus.o_busy, bus.o_done);
        end
    endtask

    task automatic test_stride1();
        int first_src [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        int lasts;
        run(1, 0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 9; i++) begin
            tests++;
            if (cap_src[i] != first_src[i] || cap_kern[i] != i || cap_last[i] != ((i == 8) ? 1 : 0)) begin
                fails++;
                $display("FAIL s1_first_window tap %0d: src %0d kern %0d last %0d, required src %0d kern %0d last %0d",
                         i, cap_src[i], cap_kern[i], cap_last[i], first_src[i], i, (i == 8) ? 1 : 0);
            end
        end
        tests++; if (cap_busy1 != 1 || cap_valid1 != 0) begin fails++; $display("FAIL s1_latency: busy %0d valid %0d after start edge, required 1 0", cap_busy1, cap_valid1); end
        tests++; if (cap_n != 324)      begin fails++; $display("FAIL s1_handshakes: %0d, required 324", cap_n); end
        tests++; if (cap_cycles != 326) begin fails++; $display("FAIL s1_run_length: %0d, required 326", cap_cycles); end
        tests++; if (cap_dest[323] != 35) begin fails++; $display("FAIL s1_last_dest: %0d, required 35", cap_dest[323]); end
        lasts = 0;
        for (int i = 0; i < cap_n; i++) lasts += cap_last[i];
        tests++; if (lasts != 36) begin fails++; $display("FAIL s1_windows: %0d, required 36", lasts); end
        build_model(1, 0, 0, 0);
        tests++;
        if (model_mismatch() != 0) begin
            fails++;
            $display("FAIL s1_sequence: first bad index %0d, n %0d, required n %0d", mm_idx, cap_n, exp_n);
        end
    endtask

    task automatic test_stride2();
        run(2, 0, 0, 0, 1'b0, 0);
        tests++; if (cap_n != 81)       begin fails++; $display("FAIL s2_handshakes: %0d, required 81", cap_n); end
        tests++; if (cap_cycles != 83)  begin fails++; $display("FAIL s2_run_length: %0d, required 83", cap_cycles); end
        tests++; if (cap_src[9] != 2)   begin fails++; $display("FAIL s2_win1_src: %0d, required 2", cap_src[9]); end
        tests++; if (cap_src[27] != 16) begin fails++; $display("FAIL s2_win3_src: %0d, required 16", cap_src[27]); end
        tests++; if (cap_src[72] != 36 || cap_dest[72] != 8) begin fails++; $display("FAIL s2_last_win: src %0d dest %0d, required 36 8", cap_src[72], cap_dest[72]); end
        build_model(2, 0, 0, 0);
        tests++;
        if (model_mismatch() != 0) begin
            fails++;
            $display("FAIL s2_sequence: first bad index %0d, n %0d, required n %0d", mm_idx, cap_n, exp_n);
        end
    endtask

    task automatic test_stride0_and_6();
        run(0, 0, 0, 0, 1'b0, 0);
        build_model(1, 0, 0, 0);
        tests++;
        if (cap_n != 324 || model_mismatch() != 0) begin
            fails++;
            $display("FAIL s0_as_s1: n %0d first bad %0d, required n 324 matching stride 1", cap_n, mm_idx);
        end
        run(6, 0, 0, 0, 1'b0, 0);
        tests++; if (cap_n != 9) begin fails++; $display("FAIL s6_handshakes: %0d, required 9", cap_n); end
        tests++; if (cap_src[8] != 18 || cap_last[8] != 1 || cap_dest[8] != 0) begin
            fails++;
            $display("FAIL s6_final_tap: src %0d last %0d dest %0d, required 18 1 0", cap_src[8], cap_last[8], cap_dest[8]);
        end
    endtask

    task automatic test_backpressure();
        run(1, 37, 5, 100, 1'b1, 0);
        build_model(1, 37, 5, 100);
        tests++;
        if (model_mismatch() != 0) begin
            fails++;
            $display("FAIL bp_sequence: first bad index %0d, n %0d, required n %0d", mm_idx, cap_n, exp_n);
        end
        tests++; if (cap_cycles <= 326) begin fails++; $display("FAIL bp_stalled: run length %0d, required more than 326", cap_cycles); end
    endtask

    task automatic test_wrap();
        int wrap_src [9] = '{1020, 1021, 1022, 4, 5, 6, 12, 13, 14};
        int bad;
        run(1, 1020, 0, 1023, 1'b0, 0);
        bad = 0;
        for (int i = 0; i < 9; i++) if (cap_src[i] != wrap_src[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL wrap_src: %0d taps wrong (tap3 %0d), required tap3 4", bad, cap_src[3]); end
        tests++; if (cap_dest[0] != 1023 || cap_dest[9] != 0) begin
            fails++;
            $display("FAIL wrap_dest: win0 %0d win1 %0d, required 1023 0", cap_dest[0], cap_dest[9]);
        end
        build_model(1, 1020, 0, 1023);
        tests++;
        if (model_mismatch() != 0) begin fails++; $display("FAIL wrap_sequence: first bad index %0d, required none", mm_idx); end
    endtask

    task automatic test_start_busy();
        run(1, 0, 0, 0, 1'b0, 50);
        build_model(1, 0, 0, 0);
        tests++;
        if (model_mismatch() != 0 || cap_cycles != 326) begin
            fails++;
            $display("FAIL busy_start_ignored: first bad %0d cycles %0d, required none 326", mm_idx, cap_cycles);
        end
        // Start pulse landing in the DONE cycle must not launch a run.
        run(6, 0, 0, 0, 1'b0, 11);
        @(negedge clk);
        tests++;
        if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
            fails++;
            $display("FAIL done_start_ignored: busy %0b valid %0b, required 0 0", bus.o_busy, bus.o_valid);
        end
    endtask

    task automatic test_reset_abort();
        bit done_seen;
        @(negedge clk);
        bus.i_stride = 3'd1;
        bus.i_src1_start_addr = 10'd100;
        bus.i_kernal_start_addr = 10'd200;
        bus.i_dest_start_addr = 10'd300;
        bus.i_ready = 1'b1;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (20) @(negedge clk);
        tests++;
        if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL abort_pre: valid %0b, required 1", bus.o_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.o_valid, bus.o_src_addr, bus.o_kern_addr, bus.o_last_tap, bus.o_dest_addr, bus.o_busy, bus.o_done} !== '0) begin
            fails++;
            $display("FAIL abort_clear: valid %0b src %0d kern %0d dest %0d busy %0b, required all 0",
                     bus.o_valid, bus.o_src_addr, bus.o_kern_addr, bus.o_dest_addr, bus.o_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.o_done || bus.o_valid) done_seen = 1'b1;
        end
        tests++;
        if (done_seen) begin fails++; $display("FAIL abort_no_done: activity after abort 1, required 0"); end
        run(1, 100, 200, 300, 1'b0, 0);
        build_model(1, 100, 200, 300);
        tests++;
        if (cap_dest[0] != 300 || model_mismatch() != 0) begin
            fails++;
            $display("FAIL abort_restart: dest0 %0d first bad %0d, required 300 none", cap_dest[0], mm_idx);
        end
    endtask

    initial begin
        bus.i_start             = 1'b0;
        bus.i_ready             = 1'b0;
        bus.i_stride            = 3'd0;
        bus.i_src1_start_addr   = '0;
        bus.i_kernal_start_addr = '0;
        bus.i_dest_start_addr   = '0;
        test_reset();
        test_stride1();
        test_stride2();
        test_stride0_and_6();
        test_backpressure();
        test_wrap();
        test_start_busy();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
